// File: rtl/uart_tx_frame_if.sv
// Valid/ready word handshake between the UART front-end (master) and uart_tx_frame (slave).
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, 1-2 stop bits.
// Defining UART_TX_BREAK_EN adds the send_break input and a line-break generator.
module uart_tx_frame #(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 19200,
  parameter int DIV_WIDTH   = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_frame_if.slave       tx_if,
  input  logic [DIV_WIDTH-1:0] baud_div,
`ifdef UART_TX_BREAK_EN
  input  logic                 send_break,
`endif
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 done_tx
);

  // state  | meaning
  // IDLE   | line high, word accepted on tx_valid
  // START  | start bit (low)
  // DATA   | data bit idx_q
  // PARITY | parity bit
  // STOP   | stop bit(s); also closes a break
  // DONE   | one-cycle done_tx pulse, not ready
  // BREAK  | line held low while send_break / minimum length

  localparam int                   DEF_DIV   = CLK_FREQ / BAUD_RATE;
  localparam int                   IDX_W     = $clog2(DATA_WIDTH + 1);
  localparam bit                   PAR_EN    = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam bit                   PAR_ODD   = (PARITY_MODE == 1);
  localparam logic [DIV_WIDTH-1:0] DEF_DIV_W = DIV_WIDTH'(DEF_DIV);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]     LAST_STOP = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
`ifdef UART_TX_BREAK_EN
    BREAK,
`endif
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  tx_q, tx_d;

  logic                  bit_end;
  logic [DIV_WIDTH-1:0]  bit_nxt;
  logic [DIV_WIDTH-1:0]  sel_div;
  logic                  par_bit;
  logic                  xfer;

  assign sel_div = (baud_div == '0) ? DEF_DIV_W : baud_div;
  assign bit_end = (bit_cnt_q == div_q - DIV_WIDTH'(1));
  assign bit_nxt = bit_end ? '0 : bit_cnt_q + DIV_WIDTH'(1);
  assign par_bit = PAR_ODD ? ~(^data_q) : (^data_q);

`ifdef UART_TX_BREAK_EN
  // Break minimum is counted in whole bit periods so the counter stays narrow for any divisor.
  localparam int               BRK_BITS = 2 * (1 + DATA_WIDTH + (PAR_EN ? 1 : 0) + STOP_BITS);
  localparam int               BRK_W    = $clog2(BRK_BITS + 1);
  localparam logic [BRK_W-1:0] BRK_MAX  = BRK_W'(BRK_BITS);

  logic [BRK_W-1:0] brk_cnt_q, brk_cnt_d;
  logic             brk_q, brk_d;
  logic             brk_min;

  assign brk_min = (brk_cnt_q == BRK_MAX) ||
                   (bit_end && (brk_cnt_q == BRK_MAX - BRK_W'(1)));
  assign tx_if.tx_ready = (state_q == IDLE) && !send_break;
  assign tx_busy = state_q inside {START, DATA, PARITY, STOP, BREAK};
`else
  assign tx_if.tx_ready = (state_q == IDLE);
  assign tx_busy = state_q inside {START, DATA, PARITY, STOP};
`endif

  assign xfer    = tx_if.tx_valid && tx_if.tx_ready;
  assign done_tx = (state_q == DONE);
  assign tx      = tx_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    idx_d     = idx_q;
    data_d    = data_q;
`ifdef UART_TX_BREAK_EN
    brk_cnt_d = brk_cnt_q;
    brk_d     = brk_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (send_break) begin
          state_d   = BREAK;
          div_d     = sel_div;
          bit_cnt_d = '0;
          idx_d     = '0;
          brk_cnt_d = '0;
          brk_d     = 1'b1;
        end else
`endif
        if (xfer) begin
          state_d   = START;
          div_d     = sel_div;
          data_d    = tx_if.tx_data;
          bit_cnt_d = '0;
          idx_d     = '0;
        end
      end
      START: begin
        bit_cnt_d = bit_nxt;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        bit_cnt_d = bit_nxt;
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = PAR_EN ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        bit_cnt_d = bit_nxt;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        bit_cnt_d = bit_nxt;
        if (bit_end) begin
          if (idx_q == LAST_STOP) begin
            idx_d = '0;
`ifdef UART_TX_BREAK_EN
            state_d = brk_q ? IDLE : DONE;
            brk_d   = 1'b0;
`else
            state_d = DONE;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: state_d = IDLE;
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        if (!send_break && brk_min) begin
          state_d   = STOP;
          bit_cnt_d = '0;
          idx_d     = '0;
        end else begin
          bit_cnt_d = bit_nxt;
          if (bit_end && (brk_cnt_q != BRK_MAX)) brk_cnt_d = brk_cnt_q + BRK_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the next state so the line level changes with the state itself.
  always_comb begin
    logic [DATA_WIDTH-1:0] data_sh;
    data_sh = data_q >> idx_d;
    tx_d    = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_sh[0];
      PARITY:  tx_d = par_bit;
`ifdef UART_TX_BREAK_EN
      BREAK:   tx_d = 1'b0;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      div_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_BREAK_EN
      brk_cnt_q <= '0;
      brk_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
`ifdef UART_TX_BREAK_EN
      brk_cnt_q <= brk_cnt_d;
      brk_q     <= brk_d;
`endif
    end
  end

endmodule
